// File: rtl/bus_arbiter2.sv
// Two-requester bus arbiter with round-robin ties and a hold limit; registers the granted byte onto bus1.
// Optional macro ARB_FIXED_PRIO_EN: requester 0 wins ties and is never preempted.
module bus_arbiter2 #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       sel,
   output logic [7:0] bus1,
   output logic       bus_vld,
   output logic [1:0] o_dbg_state
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2} state_t;

   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   state_t            r_state;
   state_t            w_next;
   logic              r_last;
   logic              w_last_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_sel;
   logic              r_vld;
   logic [7:0]        r_bus;
   logic              w_cap;
   logic              w_cap_sel;
   logic              w_hold_hit;
   logic              w_tie_own1;
   logic              w_pre_own0;

   // >= rather than ==: a waiter that shows up after the counter saturated must still get a turn.
   assign w_hold_hit = (r_hold >= HOLD_LIM);

`ifdef ARB_FIXED_PRIO_EN
   logic w_unused_last;
   assign w_unused_last = r_last;
   assign w_tie_own1    = 1'b0;
   assign w_pre_own0    = 1'b0;
`else
   assign w_tie_own1    = ~r_last;
   assign w_pre_own0    = 1'b1;
`endif

   always_comb begin
      w_next     = r_state;
      w_cap      = 1'b0;
      w_cap_sel  = 1'b0;
      w_hold_nxt = r_hold;
      w_last_nxt = r_last;
      case (r_state)
         ST_IDLE: begin
            if (req0 && req1) w_next = w_tie_own1 ? ST_OWN1 : ST_OWN0;
            else if (req0)    w_next = ST_OWN0;
            else if (req1)    w_next = ST_OWN1;
         end
         ST_OWN0: begin
            if (!req0) begin
               w_next = req1 ? ST_OWN1 : ST_IDLE;
            end else begin
               w_cap = 1'b1;
               if (req1 && w_hold_hit && w_pre_own0) w_next = ST_OWN1;
            end
         end
         ST_OWN1: begin
            if (!req1) begin
               w_next = req0 ? ST_OWN0 : ST_IDLE;
            end else begin
               w_cap     = 1'b1;
               w_cap_sel = 1'b1;
               if (req0 && w_hold_hit) w_next = ST_OWN0;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      // A new tenure restarts the hold count; otherwise each captured byte counts up to saturation.
      if ((w_next != r_state) && (w_next != ST_IDLE)) begin
         w_hold_nxt = '0;
         w_last_nxt = (w_next == ST_OWN1);
      end else if (w_cap && (r_hold != HOLD_SAT)) begin
         w_hold_nxt = r_hold + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_hold  <= '0;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_sel   <= 1'b0;
         r_vld   <= 1'b0;
         r_bus   <= 8'h00;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_nxt;
         r_hold  <= w_hold_nxt;
         r_gnt0  <= (w_next == ST_OWN0);
         r_gnt1  <= (w_next == ST_OWN1);
         r_sel   <= (w_next == ST_OWN1);
         r_vld   <= w_cap;
         if (w_cap) r_bus <= w_cap_sel ? data1 : data0;
      end
   end

   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign sel         = r_sel;
   assign bus1        = r_bus;
   assign bus_vld     = r_vld;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed scenarios plus random traffic against a tenure-based reference model.
module tb_bus_arbiter2;
   localparam int MAX_HOLD = 8;
`ifdef ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0  = 1'b0;
   logic       req1  = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic       gnt0;
   logic       gnt1;
   logic       sel;
   logic [7:0] bus1;
   logic       bus_vld;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   // Reference model: owner (-1 none), bytes captured in the current tenure, last winner.
   int         m_owner;
   int         m_tenure;
   int         m_last;
   logic       e_gnt0;
   logic       e_gnt1;
   logic       e_sel;
   logic       e_vld;
   logic [7:0] e_bus;

   bus_arbiter2 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
      .sel(sel), .bus1(bus1), .bus_vld(bus_vld), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   task automatic model_reset();
      m_owner = -1; m_tenure = 0; m_last = 1;
      e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_sel = 1'b0; e_vld = 1'b0; e_bus = 8'h00;
   endtask

   task automatic model_edge();
      int   nxt;
      logic mine;
      logic other;
      logic cap;
      logic [7:0] cb;
      nxt = m_owner; cap = 1'b0; cb = 8'h00;
      if (m_owner < 0) begin
         if (req0 && req1) nxt = FIXED ? 0 : (m_last == 1 ? 0 : 1);
         else if (req0)    nxt = 0;
         else if (req1)    nxt = 1;
      end else begin
         mine  = (m_owner == 0) ? req0 : req1;
         other = (m_owner == 0) ? req1 : req0;
         if (!mine) begin
            nxt = other ? 1 - m_owner : -1;
         end else begin
            cap = 1'b1;
            cb  = (m_owner == 0) ? data0 : data1;
            m_tenure++;
            if (other && m_tenure >= MAX_HOLD && (!FIXED || m_owner == 1)) nxt = 1 - m_owner;
         end
      end
      if (nxt >= 0 && nxt != m_owner) begin
         m_tenure = 0;
         m_last   = nxt;
      end
      m_owner = nxt;
      e_gnt0 = (nxt == 0); e_gnt1 = (nxt == 1); e_sel = (nxt == 1); e_vld = cap;
      if (cap) e_bus = cb;
   endtask

   // ---------------- drivers ----------------
   task automatic step(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
      req0 = r0; req1 = r1; data0 = d0; data1 = d1;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++; if (gnt0 !== 1'b0) begin n_errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
      n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
      n_checks++; if (sel !== 1'b0) begin n_errors++; $display("FAIL reset_sel: got %b want 0", sel); end
      n_checks++; if (bus1 !== 8'h00) begin n_errors++; $display("FAIL reset_bus1: got %h want 00", bus1); end
      n_checks++; if (bus_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b want 0", bus_vld); end
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if ({gnt0, gnt1, bus_vld} !== 3'b000) begin n_errors++; $display("FAIL reset_idle: got %b want 000", {gnt0, gnt1, bus_vld}); end
   endtask

   task automatic test_single_req0();
      apply_reset();
      step(1'b1, 1'b0, 8'hA5, 8'h00);
      n_checks++; if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL single_gnt0: got %b want 1", gnt0); end
      n_checks++; if (bus_vld !== 1'b0) begin n_errors++; $display("FAIL single_vld_early: got %b want 0", bus_vld); end
      step(1'b1, 1'b0, 8'hA5, 8'h00);
      n_checks++; if (bus1 !== 8'hA5) begin n_errors++; $display("FAIL single_bus1: got %h want a5", bus1); end
      n_checks++; if (bus_vld !== 1'b1) begin n_errors++; $display("FAIL single_vld: got %b want 1", bus_vld); end
      n_checks++; if ({sel, gnt1} !== 2'b00) begin n_errors++; $display("FAIL single_sel_gnt1: got %b want 00", {sel, gnt1}); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if ({gnt0, bus_vld} !== 2'b00) begin n_errors++; $display("FAIL single_release: got %b want 00", {gnt0, bus_vld}); end
      n_checks++; if (bus1 !== 8'hA5) begin n_errors++; $display("FAIL single_bus_hold: got %h want a5", bus1); end
   endtask

   task automatic test_tie_round_robin();
      apply_reset();
      step(1'b1, 1'b1, 8'h11, 8'h22);
      n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_errors++; $display("FAIL tie_first: got %b want 10", {gnt0, gnt1}); end
      step(1'b1, 1'b1, 8'h11, 8'h22);
      n_checks++; if (bus1 !== 8'h11) begin n_errors++; $display("FAIL tie_bus0: got %h want 11", bus1); end
      step(1'b0, 1'b1, 8'h00, 8'h33);
      n_checks++; if ({gnt0, gnt1, sel, bus_vld} !== 4'b0110) begin n_errors++; $display("FAIL tie_handover: got %b want 0110", {gnt0, gnt1, sel, bus_vld}); end
      step(1'b0, 1'b1, 8'h00, 8'h33);
      n_checks++; if (bus1 !== 8'h33) begin n_errors++; $display("FAIL tie_bus1: got %h want 33", bus1); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if ({gnt0, gnt1} !== 2'b00) begin n_errors++; $display("FAIL tie_idle: got %b want 00", {gnt0, gnt1}); end
      step(1'b1, 1'b1, 8'h44, 8'h55);
      n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_errors++; $display("FAIL tie_second: got %b want 10", {gnt0, gnt1}); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_forced_switch();
      int   n0;
      int   k;
      logic seen;
      apply_reset();
      step(1'b1, 1'b0, 8'h40, 8'h80);
      n_checks++; if (gnt0 !== 1'b1) begin n_errors++; $display("FAIL force_grant: got %b want 1", gnt0); end
      n0 = 0; k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         step(1'b1, 1'b1, 8'(8'h40 + k), 8'(8'h80 + k));
         if (bus_vld === 1'b1 && bus1[7:6] == 2'b01) n0++;
         if (gnt1 === 1'b1) seen = 1'b1;
         k++;
      end
      n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL force_timeout: got no gnt1 within %0d cycles", k); end
      n_checks++; if (n0 != MAX_HOLD) begin n_errors++; $display("FAIL force_count: got %0d bytes want %0d", n0, MAX_HOLD); end
      n_checks++; if (bus1 !== 8'(8'h40 + MAX_HOLD - 1)) begin n_errors++; $display("FAIL force_lastbyte: got %h want %h", bus1, 8'(8'h40 + MAX_HOLD - 1)); end
      n_checks++; if ({gnt0, sel} !== 2'b01) begin n_errors++; $display("FAIL force_sel: got %b want 01", {gnt0, sel}); end
      step(1'b1, 1'b1, 8'h50, 8'h90);
      n_checks++; if (bus1 !== 8'h90) begin n_errors++; $display("FAIL force_own1_byte: got %h want 90", bus1); end
      step(1'b1, 1'b0, 8'h51, 8'h00);
      n_checks++; if ({gnt0, gnt1, sel, bus_vld} !== 4'b1000) begin n_errors++; $display("FAIL force_return: got %b want 1000", {gnt0, gnt1, sel, bus_vld}); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_long_req1();
      logic [7:0] exp;
      apply_reset();
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
      step(1'b0, 1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 8'h00, 8'(i));
         n_checks++; if (gnt1 !== 1'b1) begin n_errors++; $display("FAIL long_gnt1[%0d]: got %b want 1", i, gnt1); end
         n_checks++;
         if (bus_vld !== 1'b1) begin
            n_errors++; $display("FAIL long_vld[%0d]: got %b want 1", i, bus_vld);
         end else begin
            exp = exp_q.pop_front();
            n_checks++; if (bus1 !== exp) begin n_errors++; $display("FAIL long_bus[%0d]: got %h want %h", i, bus1, exp); end
         end
      end
      n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL long_drain: got %0d left want 0", exp_q.size()); end
      exp_q.delete();
      step(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if ({gnt1, bus_vld} !== 2'b00) begin n_errors++; $display("FAIL long_release: got %b want 00", {gnt1, bus_vld}); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(1'b0, 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b1, 8'h00, 8'h5C);
      n_checks++; if ({gnt1, sel, bus_vld, bus1} !== {3'b111, 8'h5C}) begin n_errors++; $display("FAIL rmid_pre: got %b %h want 111 5c", {gnt1, sel, bus_vld}, bus1); end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if ({gnt1, sel, bus_vld} !== 3'b000) begin n_errors++; $display("FAIL rmid_async: got %b want 000", {gnt1, sel, bus_vld}); end
      n_checks++; if (bus1 !== 8'h00) begin n_errors++; $display("FAIL rmid_bus: got %h want 00", bus1); end
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 8'h66, 8'h77);
      n_checks++; if ({gnt0, gnt1, bus_vld} !== 3'b100) begin n_errors++; $display("FAIL rmid_after: got %b want 100", {gnt0, gnt1, bus_vld}); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_fixed_prio();
      int   k;
      logic seen;
      apply_reset();
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b1, 8'(i), 8'hEE);
         n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_errors++; $display("FAIL fixed_hold[%0d]: got %b want 10", i, {gnt0, gnt1}); end
      end
      apply_reset();
      step(1'b0, 1'b1, 8'h00, 8'h00);
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
         step((k >= 3), 1'b1, 8'h00, 8'(k));
         if (gnt0 === 1'b1) seen = 1'b1;
         else k++;
      end
      n_checks++; if (k != MAX_HOLD - 1) begin n_errors++; $display("FAIL fixed_preempt: got switch at owned cycle %0d want %0d", k + 1, MAX_HOLD); end
      n_checks++; if (gnt1 !== 1'b0) begin n_errors++; $display("FAIL fixed_gnt1_drop: got %b want 0", gnt1); end
      step(1'b0, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      logic r0;
      logic r1;
      apply_reset();
      r0 = 1'b0; r1 = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) r0 = ~r0;
         if ($urandom_range(0, 5) == 0) r1 = ~r1;
         step(r0, r1, 8'($urandom), 8'($urandom));
         n_checks++; if (gnt0 !== e_gnt0) begin n_errors++; $display("FAIL rnd_gnt0[%0d]: got %b want %b", i, gnt0, e_gnt0); end
         n_checks++; if (gnt1 !== e_gnt1) begin n_errors++; $display("FAIL rnd_gnt1[%0d]: got %b want %b", i, gnt1, e_gnt1); end
         n_checks++; if (sel !== e_sel) begin n_errors++; $display("FAIL rnd_sel[%0d]: got %b want %b", i, sel, e_sel); end
         n_checks++; if (bus_vld !== e_vld) begin n_errors++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, bus_vld, e_vld); end
         n_checks++; if (bus1 !== e_bus) begin n_errors++; $display("FAIL rnd_bus[%0d]: got %h want %h", i, bus1, e_bus); end
         n_checks++; if ((gnt0 & gnt1) !== 1'b0) begin n_errors++; $display("FAIL rnd_onehot[%0d]: got both grants", i); end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_single_req0();
      test_tie_round_robin();
`ifdef ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_forced_switch();
`endif
      test_long_req1();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
